// File: rtl/seq_match_logger.sv
// seq_match_logger: turns match level rising edges into timestamped events buffered in a FIFO
module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       match_in,
  input  logic                       clear,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_ts,
  output logic [CNT_W-1:0]           evt_count,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state;
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            rise, full, pop, push;

  // Edge detect, full check and handshake; clear suppresses every FIFO update
  always_comb begin
    rise      = (state == IDLE) && match_in;
    full      = fifo_level == LW'(DEPTH);
    evt_valid = fifo_level != '0;
    pop       = evt_valid && evt_ready && !clear;
    push      = rise && !clear && (!full || pop);
    evt_ts    = evt_valid ? mem[rd_ptr] : '0;
  end

  // Edge FSM, timestamp counter, FIFO pointers/level and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ts_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      evt_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= match_in ? HOLD : IDLE;
      if (clear) begin
        ts_cnt     <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        evt_count  <= '0;
        overflow   <= 1'b0;
      end else begin
        ts_cnt     <= ts_cnt + 1'b1;
        wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
        fifo_level <= fifo_level + LW'(push) - LW'(pop);
        evt_count  <= (rise && evt_count != '1) ? evt_count + 1'b1 : evt_count;
        overflow   <= overflow || (rise && full && !pop);
      end
    end
  end

  // Event storage; contents need no reset since evt_ts is masked when empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ts_cnt;
  end
endmodule

// File: tb/tb_seq_match_logger.sv
// tb_seq_match_logger: directed scoreboard bench for seq_match_logger
module tb_seq_match_logger;
  logic        clk = 1'b0, reset = 1'b1, match_in = 1'b0, clear = 1'b0, evt_ready = 1'b0, match_w = 1'b0;
  logic        evt_valid, overflow, evt_valid_w, overflow_w;
  logic [15:0] evt_ts;
  logic [3:0]  evt_ts_w;
  logic [7:0]  evt_count, evt_count_w;
  logic [2:0]  fifo_level, fifo_level_w;
  int          checks = 0, errors = 0, tb_ts = 0, exp_cnt = 0;
  logic        m_prev = 1'b0, exp_ovf = 1'b0;
  logic [15:0] q[$];

  seq_match_logger dut (
    .clk(clk), .reset(reset), .match_in(match_in), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts),
    .evt_count(evt_count), .overflow(overflow), .fifo_level(fifo_level)
  );

  seq_match_logger #(.TS_W(4)) dut_w (
    .clk(clk), .reset(reset), .match_in(match_w), .clear(1'b0),
    .evt_valid(evt_valid_w), .evt_ready(1'b0), .evt_ts(evt_ts_w),
    .evt_count(evt_count_w), .overflow(overflow_w), .fifo_level(fifo_level_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    logic pop, rise;
    chk("valid", 32'(evt_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("head_ts", 32'(evt_ts), 32'(q[0]));
    pop  = evt_ready && q.size() != 0;
    rise = match_in && !m_prev;
    @(posedge clk);
    if (clear) begin
      q.delete();
      exp_cnt = 0;
      exp_ovf = 1'b0;
      tb_ts   = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (rise) begin
        if (q.size() < 4) q.push_back(16'(tb_ts));
        else exp_ovf = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
      tb_ts++;
    end
    m_prev = match_in;
    #1;
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("count", 32'(evt_count), 32'(exp_cnt));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic wait_ts(input int t);
    while (tb_ts < t) tick();
  endtask

  task automatic pulse(input int t);
    wait_ts(t);
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
  endtask

  task automatic apply_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_ts", 32'(evt_ts), 0);
    chk("rst_count", 32'(evt_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_level", 32'(fifo_level), 0);
    q.delete();
    exp_cnt = 0; exp_ovf = 1'b0; m_prev = 1'b0; tb_ts = 0;
    match_in = 1'b0; clear = 1'b0; evt_ready = 1'b0; match_w = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int p3[5] = '{10, 13, 16, 19, 22};
    // T1 single event
    apply_reset();
    evt_ready = 1'b1;
    pulse(5);
    chk("t1_valid", 32'(evt_valid), 1);
    chk("t1_ts", 32'(evt_ts), 5);
    chk("t1_count", 32'(evt_count), 1);
    tick();
    chk("t1_empty", 32'(evt_valid), 0);
    // T2 held level gives one event
    apply_reset();
    wait_ts(20);
    match_in = 1'b1;
    repeat (10) tick();
    match_in = 1'b0;
    tick();
    chk("t2_count", 32'(evt_count), 1);
    chk("t2_level", 32'(fifo_level), 1);
    chk("t2_ts", 32'(evt_ts), 20);
    evt_ready = 1'b1;
    tick();
    chk("t2_empty", 32'(evt_valid), 0);
    // T3 overflow then drain in order
    apply_reset();
    foreach (p3[i]) pulse(p3[i]);
    chk("t3_level", 32'(fifo_level), 4);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_count", 32'(evt_count), 5);
    chk("t3_head", 32'(evt_ts), 10);
    evt_ready = 1'b1;
    repeat (4) tick();
    chk("t3_empty", 32'(evt_valid), 0);
    // T4 push and pop on a full FIFO
    apply_reset();
    for (int t = 2; t <= 8; t += 2) pulse(t);
    wait_ts(10);
    match_in = 1'b1;
    evt_ready = 1'b1;
    tick();
    match_in = 1'b0;
    evt_ready = 1'b0;
    chk("t4_level", 32'(fifo_level), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head", 32'(evt_ts), 4);
    evt_ready = 1'b1;
    repeat (3) tick();
    chk("t4_tail", 32'(evt_ts), 10);
    tick();
    // T5 timestamp wrap on a 4-bit instance, then count saturation
    apply_reset();
    evt_ready = 1'b1;
    wait_ts(17);
    match_w = 1'b1;
    tick();
    match_w = 1'b0;
    tick();
    chk("t5_wrap_valid", 32'(evt_valid_w), 1);
    chk("t5_wrap_ts", 32'(evt_ts_w), 1);
    repeat (300) begin
      match_in = 1'b1;
      tick();
      match_in = 1'b0;
      tick();
    end
    chk("t5_sat", 32'(evt_count), 255);
    // T6 clear with coincident edge, then async reset between clocks
    apply_reset();
    pulse(2); pulse(4); pulse(6);
    chk("t6_pre_level", 32'(fifo_level), 3);
    wait_ts(8);
    clear = 1'b1;
    match_in = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    match_in = 1'b0;
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_count", 32'(evt_count), 0);
    chk("t6_valid", 32'(evt_valid), 0);
    pulse(3);
    pulse(5);
    chk("t6_refill", 32'(fifo_level), 2);
    #3 reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(evt_valid), 0);
    chk("t6_async_level", 32'(fifo_level), 0);
    chk("t6_async_count", 32'(evt_count), 0);
    chk("t6_async_ts", 32'(evt_ts), 0);
    apply_reset();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
